output_decision_filter: RTL and testbench

- Parametrised successor to the light-decision stage. Consumes the classifier's final answer code plus its done strobe and drives a one-hot light bank.
- Adds N-in-a-row confirmation filtering, a stale-answer timeout that blanks the lights, optional blinking for one alert code, and a change strobe.
- Sits between the final classification stage and the board LEDs.

---
 rtl/output_decision_filter.sv | 88 ++++++++
 tb/tb_output_decision_filter.sv | 121 ++++++++++++
 2 files changed

// File: rtl/output_decision_filter.sv
// output_decision_filter: confirms repeated classifier answers, drives a one-hot light bank
// with stale-answer blanking, optional alert-code blinking and a change strobe.
module output_decision_filter #(
  parameter int CODE_W         = 3,
  parameter int NUM_LIGHTS     = 5,
  parameter int CONFIRM        = 3,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int BLINK_EN       = 1,
  parameter int BLINK_CODE     = 4,
  parameter int BLINK_HALF     = 25000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CODE_W-1:0]     finalAnswer,
  input  logic                  finalDone,
  output logic [NUM_LIGHTS-1:0] lightOut,
  output logic                  lightChanged,
  output logic                  stale,
  output logic [CODE_W-1:0]     confirmedAnswer
);
  localparam int IW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int BW = BLINK_HALF > 1 ? $clog2(BLINK_HALF) : 1;
  localparam bit BLINK_OK = BLINK_EN != 0 && BLINK_CODE < NUM_LIGHTS;
  localparam int BI = BLINK_OK ? BLINK_CODE : 0;
  localparam logic [IW-1:0] TO_LAST = IW'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [IW-1:0] TO_MAX = IW'(TIMEOUT_CYCLES);
  localparam logic [BW-1:0] B_LAST = BW'(BLINK_HALF - 1);
  localparam logic [3:0] C_MAX = 4'(CONFIRM);

  logic [CODE_W-1:0]     r_cand;
  logic [3:0]            r_cnt;
  logic [IW-1:0]         r_idle;
  logic [BW-1:0]         r_bcnt;
  logic                  r_phase;
  logic [NUM_LIGHTS-1:0] r_dec;

  logic                  w_match, w_to, w_conf, w_stale, w_bwrap, w_phase;
  logic [3:0]            w_cnt;
  logic [IW-1:0]         w_idle;
  logic [BW-1:0]         w_bcnt;
  logic [CODE_W-1:0]     w_code;
  logic [NUM_LIGHTS-1:0] w_onehot, w_dec, w_light;

  always_comb begin
    w_match  = finalDone && finalAnswer == r_cand && r_cnt != 4'd0;
    w_to     = TIMEOUT_CYCLES > 0 && !finalDone && r_idle == TO_LAST;
    w_cnt    = finalDone ? (w_match ? (r_cnt == C_MAX ? C_MAX : r_cnt + 4'd1) : 4'd1)
                         : (w_to ? 4'd0 : r_cnt);
    w_conf   = finalDone && w_cnt == C_MAX;
    w_idle   = finalDone ? '0 : (r_idle == TO_MAX ? r_idle : r_idle + IW'(1));
    w_onehot = 32'(finalAnswer) < NUM_LIGHTS ? NUM_LIGHTS'(1) << finalAnswer : '0;
    w_code   = w_conf ? finalAnswer : confirmedAnswer;
    w_stale  = w_conf ? 1'b0 : (w_to ? 1'b1 : stale);
    w_dec    = w_conf ? w_onehot : (w_to ? '0 : r_dec);
    w_bwrap  = r_bcnt == B_LAST;
    w_bcnt   = (w_conf || w_bwrap) ? '0 : r_bcnt + BW'(1);
    w_phase  = w_conf ? 1'b1 : (w_bwrap ? ~r_phase : r_phase);
    w_light  = w_dec;
    // the blink bit follows the phase only while the alert code is the live decision
    if (BLINK_OK && w_code == CODE_W'(BLINK_CODE) && !w_stale) w_light[BI] = w_phase;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cand          <= '0;
      r_cnt           <= '0;
      r_idle          <= '0;
      r_bcnt          <= '0;
      r_phase         <= 1'b1;
      r_dec           <= '0;
      lightOut        <= '0;
      lightChanged    <= 1'b0;
      stale           <= 1'b0;
      confirmedAnswer <= '0;
    end else begin
      r_cand          <= finalDone ? finalAnswer : r_cand;
      r_cnt           <= w_cnt;
      r_idle          <= w_idle;
      r_bcnt          <= w_bcnt;
      r_phase         <= w_phase;
      r_dec           <= w_dec;
      lightOut        <= w_light;
      lightChanged    <= w_code != confirmedAnswer || w_stale != stale;
      stale           <= w_stale;
      confirmedAnswer <= w_code;
    end
  end
endmodule

// File: tb/tb_output_decision_filter.sv
// tb_output_decision_filter: directed vectors against two instances, blink disabled (a) and enabled (b).
module tb_output_decision_filter;
  logic       clk, rst, finalDone;
  logic [2:0] finalAnswer;
  logic [4:0] a_light, b_light;
  logic       a_chg, b_chg, a_stale, b_stale;
  logic [2:0] a_conf, b_conf;
  int n_chk = 0, n_err = 0;

  output_decision_filter #(.CONFIRM(3), .TIMEOUT_CYCLES(20), .BLINK_EN(0), .BLINK_HALF(4)) u_a (
    .clk(clk), .rst(rst), .finalAnswer(finalAnswer), .finalDone(finalDone),
    .lightOut(a_light), .lightChanged(a_chg), .stale(a_stale), .confirmedAnswer(a_conf));

  output_decision_filter #(.CONFIRM(3), .TIMEOUT_CYCLES(20), .BLINK_EN(1), .BLINK_HALF(4)) u_b (
    .clk(clk), .rst(rst), .finalAnswer(finalAnswer), .finalDone(finalDone),
    .lightOut(b_light), .lightChanged(b_chg), .stale(b_stale), .confirmedAnswer(b_conf));

  always #5 clk = ~clk;

  task automatic tick(input logic d, input logic [2:0] a);
    finalDone = d;
    finalAnswer = a;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  initial begin
    clk = 0; rst = 1; finalDone = 1; finalAnswer = 3'd2;
    tick(1, 3'd2);
    check("rst_light", a_light, 0);
    check("rst_chg", a_chg, 0);
    check("rst_stale", a_stale, 0);
    check("rst_conf", a_conf, 0);
    rst = 0;
    // basic confirmation of code 2
    tick(1, 3'd2); check("c2_s1", a_light, 0);
    tick(1, 3'd2); check("c2_s2", a_light, 0);
    tick(1, 3'd2);
    check("c2_light", a_light, 5'b00100);
    check("c2_conf", a_conf, 2);
    check("c2_chg", a_chg, 1);
    tick(0, 3'd0); check("c2_chg_once", a_chg, 0);
    // broken run 1,1,3,1,1,1
    tick(1, 3'd1); check("run_1", a_light, 5'b00100);
    tick(1, 3'd1); check("run_2", a_light, 5'b00100);
    tick(1, 3'd3); check("run_3", a_light, 5'b00100);
    tick(1, 3'd1); check("run_4", a_light, 5'b00100);
    tick(1, 3'd1); check("run_5", a_light, 5'b00100);
    tick(1, 3'd1);
    check("run_6_light", a_light, 5'b00010);
    check("run_6_conf", a_conf, 1);
    check("run_6_chg", a_chg, 1);
    // timeout after 20 idle cycles
    repeat (3) tick(1, 3'd2);
    check("to_pre_conf", a_conf, 2);
    for (int i = 1; i < 20; i++) tick(0, 3'd0);
    check("to_19_stale", a_stale, 0);
    check("to_19_light", a_light, 5'b00100);
    tick(0, 3'd0);
    check("to_20_light", a_light, 0);
    check("to_20_stale", a_stale, 1);
    check("to_20_chg", a_chg, 1);
    check("to_20_conf", a_conf, 2);
    tick(0, 3'd0);
    check("to_chg_once", a_chg, 0);
    check("to_stale_hold", a_stale, 1);
    // reconfirm clears stale; done on the 20th cycle prevents timeout
    repeat (3) tick(1, 3'd2);
    check("rc_stale", a_stale, 0);
    check("rc_chg", a_chg, 1);
    for (int i = 1; i < 20; i++) tick(0, 3'd0);
    tick(1, 3'd2);
    check("nto_stale", a_stale, 0);
    check("nto_light", a_light, 5'b00100);
    check("nto_chg", a_chg, 0);
    // out-of-range code
    repeat (3) tick(1, 3'd6);
    check("c6_light", a_light, 0);
    check("c6_stale", a_stale, 0);
    check("c6_conf", a_conf, 6);
    check("c6_chg", a_chg, 1);
    // blink of code 4
    repeat (3) tick(1, 3'd4);
    check("bl_light0", b_light, 5'b10000);
    check("bl_conf", b_conf, 4);
    check("bl_chg0", b_chg, 1);
    check("bl_a_steady0", a_light, 5'b10000);
    for (int i = 1; i <= 12; i++) begin
      tick(0, 3'd0);
      check($sformatf("bl_light%0d", i), b_light, ((i / 4) % 2 == 0) ? 5'b10000 : 5'b00000);
      check($sformatf("bl_chg%0d", i), b_chg, 0);
      check($sformatf("bl_a_steady%0d", i), a_light, 5'b10000);
    end
    // reset mid-run
    repeat (3) tick(1, 3'd2);
    tick(1, 3'd1); tick(1, 3'd1);
    check("mr_pre_light", a_light, 5'b00100);
    rst = 1;
    tick(1, 3'd1);
    rst = 0;
    check("mr_light", a_light, 0);
    check("mr_conf", a_conf, 0);
    check("mr_chg", a_chg, 0);
    check("mr_stale", a_stale, 0);
    check("mr_b_light", b_light, 0);
    tick(1, 3'd1); check("mr_s1", a_light, 0);
    tick(1, 3'd1); check("mr_s2", a_light, 0);
    check("mr_s2_conf", a_conf, 0);
    tick(1, 3'd1); check("mr_s3", a_light, 5'b00010);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
